// File: rtl/ntt_out_serializer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ntt_out_serializer_if
// Brief  : Frame-in / word-out handshake bundle for the NTT output serializer.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface ntt_out_serializer_if #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32
);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_start;
  logic [DATA_WIDTH_PER_INPUT-1:0] in_data [INPUT_PER_CYCLE];
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH_PER_INPUT-1:0] out_data;
  logic                            out_start;
  logic                            out_last;

  // master: frame producer plus word consumer; slave: the serializer
  modport master (
    output in_valid, in_start, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_start, out_last
  );

  modport slave (
    input  in_valid, in_start, in_data, out_ready,
    output in_ready, out_valid, out_data, out_start, out_last
  );
endinterface
`default_nettype wire

// File: rtl/ntt_out_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ntt_out_serializer
// Brief  : Ping-pong buffered parallel-to-serial converter for NTT output
//          frames. Define NTT_SER_BITREV_EN for bit-reversed word order.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module ntt_out_serializer #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32
) (
  input wire clk,
  input wire rst,
  ntt_out_serializer_if.slave bus
);

  localparam int                 c_CNT_W = $clog2(INPUT_PER_CYCLE);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(INPUT_PER_CYCLE - 1);

  logic [DATA_WIDTH_PER_INPUT-1:0] r_buf [2][INPUT_PER_CYCLE];
  logic [1:0]                      r_full;
  logic [1:0]                      r_start;
  logic                            r_wsel;
  logic                            r_rsel;
  logic                            r_live;
  logic [c_CNT_W-1:0]              r_cnt;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_wrap;
  logic [c_CNT_W-1:0] w_idx;

  // Occupancy (EMPTY/HALF/FULL) is the number of set full flags; with the
  // pointers toggling on use, full[wsel] is set only when both buffers are.
  assign w_in_ready  = r_live & ~r_full[r_wsel];
  assign w_out_valid = r_full[r_rsel];
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_wrap      = (r_cnt == c_LAST);

`ifdef NTT_SER_BITREV_EN
  generate
    for (genvar b = 0; b < c_CNT_W; b++) begin : g_bitrev
      assign w_idx[b] = r_cnt[c_CNT_W-1-b];
    end
  endgenerate
`else
  assign w_idx = r_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_buf[r_rsel][w_idx];
  assign bus.out_start = w_out_valid & (r_cnt == '0) & r_start[r_rsel];
  assign bus.out_last  = w_out_valid & w_wrap;

  // r_live keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full  <= '0;
      r_start <= '0;
      r_wsel  <= 1'b0;
      r_rsel  <= 1'b0;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_in_fire) begin
        r_full[r_wsel]  <= 1'b1;
        r_start[r_wsel] <= bus.in_start;
        r_wsel          <= ~r_wsel;
      end
      // in_fire targets an empty buffer and out_fire a full one, so the
      // two full-flag writes never collide.
      if (w_out_fire) begin
        if (w_wrap) begin
          r_cnt          <= '0;
          r_full[r_rsel] <= 1'b0;
          r_rsel         <= ~r_rsel;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int i = 0; i < INPUT_PER_CYCLE; i++) begin
        r_buf[r_wsel][i] <= bus.in_data[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_out_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_ntt_out_serializer
// Brief  : Randomized self-checking bench with a word-queue reference model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_ntt_out_serializer;

  localparam int DW  = 32;
  localparam int IPC = 32;
  localparam int CW  = $clog2(IPC);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_out_serializer_if #(.DATA_WIDTH_PER_INPUT(DW), .INPUT_PER_CYCLE(IPC)) bus ();

  ntt_out_serializer #(
    .DATA_WIDTH_PER_INPUT(DW),
    .INPUT_PER_CYCLE     (IPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          start;
    logic          last;
  } word_t;

  word_t exp_q[$];
  int    n_tests    = 0;
  int    n_fail     = 0;
  int    words_out  = 0;
  int    ready_mode = 0;
  int    phase      = 0;
  bit    live       = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion at %0t", tag, $time);
  endtask

  function automatic int src_idx(input int k);
    int r;
    r = k;
`ifdef NTT_SER_BITREV_EN
    r = 0;
    for (int b = 0; b < CW; b++) r = r * 2 + ((k >> b) & 1);
`endif
    return r;
  endfunction

  // Input side is live from the first clock edge after reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) live = 1'b0;
    else      live = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = (phase == 0);
        phase = (phase + 1) % 3;
      end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: outputs are compared every cycle (so stalls must hold them),
  // then a frame accepted at the coming edge is expanded into words.
  always @(negedge clk) begin : mon
    int    frames;
    word_t w;
    if (!rst) begin
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_in_ready",  bus.in_ready,  0);
      exp_q.delete();
    end else begin
      frames = (exp_q.size() + IPC - 1) / IPC;
      check_eq("in_ready",  bus.in_ready,  live && frames < 2);
      check_eq("out_valid", bus.out_valid, exp_q.size() != 0);
      if (bus.out_valid && exp_q.size() != 0) begin
        check_eq("out_data",  bus.out_data,  exp_q[0].data);
        check_eq("out_start", bus.out_start, exp_q[0].start);
        check_eq("out_last",  bus.out_last,  exp_q[0].last);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          words_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int k = 0; k < IPC; k++) begin
          w.data  = bus.in_data[src_idx(k)];
          w.start = bus.in_start && (k == 0);
          w.last  = (k == IPC - 1);
          exp_q.push_back(w);
        end
      end
    end
  end

  task automatic send_frame(input bit start, input bit rnd, input int base);
    bus.in_valid = 1'b1;
    bus.in_start = start;
    for (int i = 0; i < IPC; i++) bus.in_data[i] = rnd ? DW'($urandom) : DW'(base + i);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        return;
      end
    end
    timeout_fail("send_frame");
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.out_valid) return;
    end
    timeout_fail("drain");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    for (int i = 0; i < IPC; i++) bus.in_data[i] = '0;

    #1;
    check_eq("reset_out_valid", bus.out_valid, 0);
    check_eq("reset_out_start", bus.out_start, 0);
    check_eq("reset_out_last",  bus.out_last,  0);
    check_eq("reset_in_ready",  bus.in_ready,  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", bus.in_ready, 1);

    // single frame 100..131 with start
    send_frame(1'b1, 1'b0, 100);
    wait_drain();

    // three frames back to back; frame 3 lands as frame 1 completes
    send_frame(1'b1, 1'b1, 0);
    send_frame(1'b0, 1'b1, 0);
    send_frame(1'b1, 1'b1, 0);
    wait_drain();

    // backpressure 1,0,0,...
    ready_mode = 1;
    for (int f = 0; f < 3; f++) send_frame(1'($urandom_range(0, 1)), 1'b1, 0);
    wait_drain();

    // random backpressure and input gaps
    ready_mode = 2;
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      send_frame(1'($urandom_range(0, 1)), 1'b1, 0);
    end
    wait_drain();

    // reset after word 10 of a frame
    ready_mode = 0;
    base = words_out;
    send_frame(1'b1, 1'b1, 0);
    begin : wait_words
      for (int t = 0; t < 200; t++) begin
        @(posedge clk);
        if (words_out - base >= 11) disable wait_words;
      end
      timeout_fail("mid_frame_wait");
    end
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_out_start", bus.out_start, 0);
    check_eq("midrst_out_last",  bus.out_last,  0);
    check_eq("midrst_in_ready",  bus.in_ready,  0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_ready_after", bus.in_ready, 1);
    send_frame(1'b1, 1'b0, 500);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
